line_arbiter: RTL and testbench
===============================

Name: line_arbiter

Overview:
- Arbitrates between the instruction-side and data-side cacheline miss ports and drives one shared physical-memory port.
- Sits directly downstream of the pipeline's inst/data memory interfaces, between the I-cache and D-cache miss ports and pmem.
- One transaction is outstanding at a time.
- Address and write data are latched at grant, so pmem sees stable values regardless of requester behaviour.

Parameters:
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, byte address width; line-aligned, low 5 bits forwarded unchanged

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous active-low reset
- i_read  in  1  I-side line read request, held until i_resp
- i_addr  in  ADDR_W  I-side line address
- i_rdata  out  LINE_W  I-side returned line
- i_resp  out  1  I-side completion pulse
- d_read  in  1  D-side line read request, held until d_resp
- d_write  in  1  D-side line write request, held until d_resp
- d_addr  in  ADDR_W  D-side line address
- d_wdata  in  LINE_W  D-side write line
- d_rdata  out  LINE_W  D-side returned line
- d_resp  out  1  D-side completion pulse
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_addr  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write line
- pmem_rdata  in  LINE_W  memory read line
- pmem_resp  in  1  memory completion, one cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - pmem_read=pmem_write=0; pmem_addr=0; pmem_wdata=0.
  - i_resp=d_resp=0.
  - last_grant=I.
  - Reset mid-transaction abandons the transaction; strobes drop immediately with no resp to either side.
- States:
  - IDLE: no request pending → stay.
  - Requests pending → grant per priority and latch the granted side's addr (plus wdata and op for D) into pmem_addr/pmem_wdata/op. Enter SERVE_I or SERVE_D on the next edge.
  - SERVE_x: pmem_read or pmem_write is asserted from the latched op, held until pmem_resp.
  - On pmem_resp=1 in SERVE_x: x_resp=1 in the same cycle (combinational from pmem_resp and state); x_rdata=pmem_rdata. Next state DONE; last_grant=x.
  - DONE: exactly one cycle with strobes low and both resps low, giving the requester time to drop its request. Next state IDLE.
- Priority (macro absent): D beats I when both are pending in IDLE.
- Latency:
  - Grant takes 1 cycle after the request is seen in IDLE.
  - The strobe rises on the first SERVE cycle.
  - Minimum request-to-resp is 2 cycles (pmem_resp on the first SERVE cycle). Back-to-back grants are separated by 2 idle cycles (DONE, IDLE).
- d_read and d_write both high is illegal; write wins.
- Requests that change or drop after grant have no effect on the in-flight transaction.
- i_rdata/d_rdata continuously mirror pmem_rdata. They are valid only while the matching resp=1.
- Both resps are never high in the same cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous pending requests in IDLE, grant the side opposite last_grant, preventing I-side starvation under continuous D traffic.
- Undefined: fixed D-over-I priority; last_grant is still tracked but unused.

Decomposition:
- A shared package (rv32i_types or an arbiter package) holds:
  - the enum arb_state_t {IDLE, SERVE_I, SERVE_D, DONE};
  - the grant enum {GRANT_I, GRANT_D};
  - the LINE_W default constant.
- No sub-module. A single always_ff for state/latches plus an always_comb for outputs and next-state.

Test Plan:
- I-only read: i_addr=0x0000_0060, i_read=1 → grant next edge → pmem_read=1, pmem_addr=0x60. With pmem_resp after 3 cycles and pmem_rdata=0xA5..A5: i_resp=1 for one cycle, i_rdata=0xA5..A5, d_resp stays 0.
- D write: d_addr=0x0000_1020, d_wdata=0x1234..5678, d_write=1 → pmem_write=1, pmem_addr=0x1020, pmem_wdata=0x1234..5678 held until pmem_resp. Then d_resp=1, followed by one DONE cycle with strobes low.
- Simultaneous i_read and d_read at 0x100/0x200:
  - Macro off: D served first (pmem_addr=0x200), then I (0x100).
  - Macro on after a prior D grant: I served first.
- Address hold: change d_addr from 0x300 to 0x400 mid-SERVE_D → pmem_addr stays 0x300 until resp.
- Reset mid-op: assert rst=0 during SERVE_I → pmem_read=0 in the same cycle, no i_resp. After release, state is IDLE and a fresh i_read is served normally.
- Illegal op: d_read=d_write=1 → pmem_write=1, pmem_read=0.

Source files
------------

// File: rtl/line_arbiter_pkg.sv
// Shared types for the I/D cacheline miss arbiter: FSM states, grant
// identifiers and default widths.
package line_arbiter_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  function automatic grant_t opposite_grant(input grant_t g);
    return (g == GRANT_I) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/line_arbiter.sv
// Arbitrates I-side and D-side cacheline misses onto one pmem port, one
// transaction at a time. Define ARB_ROUND_ROBIN_EN for alternating grants on contention.
module line_arbiter
  import line_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_reg, state_next;
  grant_t            last_grant_reg, last_grant_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LINE_W-1:0] wdata_reg, wdata_next;
  logic              write_reg, write_next;

  logic   i_pend;
  logic   d_pend;
  logic   serving;
  grant_t pick;

  always_comb begin
    i_pend          = i_read;
    d_pend          = d_read | d_write;
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    write_next      = write_reg;

    // Contention policy: fixed D priority unless round robin is built in.
    if (i_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick = opposite_grant(last_grant_reg);
`else
      pick = GRANT_D;
`endif
    end else if (d_pend) begin
      pick = GRANT_D;
    end else begin
      pick = GRANT_I;
    end

    unique case (state_reg)
      IDLE: begin
        if (i_pend || d_pend) begin
          if (pick == GRANT_D) begin
            state_next = SERVE_D;
            addr_next  = d_addr;
            wdata_next = d_wdata;
            // Read+write together is illegal; treating it as a write keeps dirty data safe.
            write_next = d_write;
          end else begin
            state_next = SERVE_I;
            addr_next  = i_addr;
            write_next = 1'b0;
          end
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_next      = DONE;
          last_grant_next = GRANT_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_next      = DONE;
          last_grant_next = GRANT_D;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    serving    = (state_reg == SERVE_I) || (state_reg == SERVE_D);
    pmem_read  = serving && !write_reg;
    pmem_write = serving && write_reg;
    pmem_addr  = addr_reg;
    pmem_wdata = wdata_reg;
    i_resp     = (state_reg == SERVE_I) && pmem_resp;
    d_resp     = (state_reg == SERVE_D) && pmem_resp;
    i_rdata    = pmem_rdata;
    d_rdata    = pmem_rdata;
  end

  // Strobes decode from state_reg, so an asynchronous reset drops them at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_I;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      write_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      write_reg      <= write_next;
    end
  end

endmodule

// File: tb/tb_line_arbiter.sv
// Scoreboard bench for line_arbiter: requesters, a random-latency pmem model,
// and a monitor that checks each pmem transaction against an ordered expectation queue.
module tb_line_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  line_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_d;
    logic [AW-1:0] addr;
    bit            wr;
    logic [LW-1:0] wdata;
  } exp_t;

  exp_t          exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_txn = 0;
  bit            mon_en = 1'b0;
  bit            pmem_auto = 1'b0;
  bit            model_last_d = 1'b0;
  logic [LW-1:0] resp_data = '0;
  exp_t          mon_cur;
  bit            mon_in_txn = 1'b0;
  int            mon_gap = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // pmem model: answers each strobe after 0..3 extra cycles with a fresh random line.
  initial begin : pmem_model
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (pmem_auto && (pmem_read || pmem_write)) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          #1;
        end
        resp_data  = rand_line();
        pmem_rdata = resp_data;
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp  = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) begin
        mon_in_txn = 1'b0;
        mon_gap    = 0;
      end else begin
        if (!mon_in_txn && (pmem_read || pmem_write)) begin
          chk("grant_gap", LW'(mon_gap), '0);
          if (exp_q.size() == 0) begin
            fail_now("unexpected_txn");
          end else begin
            mon_cur    = exp_q.pop_front();
            mon_in_txn = 1'b1;
          end
        end
        if (mon_in_txn) begin
          chk("pmem_read", LW'(pmem_read), LW'(!mon_cur.wr));
          chk("pmem_write", LW'(pmem_write), LW'(mon_cur.wr));
          chk("pmem_addr", LW'(pmem_addr), LW'(mon_cur.addr));
          if (mon_cur.wr) chk("pmem_wdata", pmem_wdata, mon_cur.wdata);
          if (pmem_resp) begin
            chk("i_resp", LW'(i_resp), LW'(!mon_cur.is_d));
            chk("d_resp", LW'(d_resp), LW'(mon_cur.is_d));
            chk("rdata", mon_cur.is_d ? d_rdata : i_rdata, resp_data);
            n_txn++;
            $display("txn %0d side=%s op=%s addr=%h", n_txn, mon_cur.is_d ? "D" : "I",
                     mon_cur.wr ? "WR" : "RD", mon_cur.addr);
            mon_in_txn = 1'b0;
            mon_gap    = 2;
          end else begin
            chk("resp_early", LW'({i_resp, d_resp}), '0);
          end
        end else begin
          chk("resp_idle", LW'({i_resp, d_resp}), '0);
          if (mon_gap > 0) mon_gap--;
        end
      end
    end
  end

  // One arbitration round: model the service order, raise requests, hold until resp.
  task automatic do_round(input bit ir, input logic [AW-1:0] ia, input bit drd, input bit dwr,
                          input logic [AW-1:0] da, input logic [LW-1:0] dwd, input bit pert);
    bit ord[2];
    int nord;
    int served;
    int cyc;
    bit dp;
    bit i_done;
    bit d_done;
    exp_t e;
    dp = drd | dwr;
    if (ir && dp) begin
`ifdef ARB_ROUND_ROBIN_EN
      ord[0] = !model_last_d;
`else
      ord[0] = 1'b1;
`endif
      ord[1] = !ord[0];
      nord   = 2;
    end else begin
      ord[0] = dp;
      ord[1] = 1'b0;
      nord   = 1;
    end
    for (int k = 0; k < nord; k++) begin
      e.is_d  = ord[k];
      e.addr  = ord[k] ? da : ia;
      e.wr    = ord[k] && dwr;
      e.wdata = dwd;
      exp_q.push_back(e);
    end
    model_last_d = ord[nord-1];

    @(negedge clk);
    i_read  = ir;
    i_addr  = ia;
    d_read  = drd;
    d_write = dwr;
    d_addr  = da;
    d_wdata = dwd;
    i_done  = !ir;
    d_done  = !dp;
    served  = 0;
    cyc     = 0;
    while (1) begin
      #3;
      if (cyc == 0) chk("grant_latency_idle", LW'(pmem_read | pmem_write), '0);
      if (cyc == 1) chk("grant_latency_strobe", LW'(pmem_read | pmem_write), LW'(1));
      if (pert && served < nord && (pmem_read || pmem_write) && $urandom_range(0, 1) == 1) begin
        if (ord[served]) begin
          d_addr  = $urandom;
          d_wdata = rand_line();
          if (d_read != d_write) {d_read, d_write} = {d_write, d_read};
        end else begin
          i_addr = $urandom;
        end
      end
      if (i_resp && !i_done) begin
        i_done = 1'b1;
        served++;
      end
      if (d_resp && !d_done) begin
        d_done = 1'b1;
        served++;
      end
      @(negedge clk);
      if (i_done) i_read = 1'b0;
      if (d_done) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
      cyc++;
      if (i_done && d_done) break;
      if (cyc > 40) begin
        fail_now("round_timeout");
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        exp_q.delete();
        break;
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit            ir;
    int            dsel;
    logic [LW-1:0] line;
    rst     = 1'b0;
    i_read  = 1'b0;
    i_addr  = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_pmem_read", LW'(pmem_read), '0);
    chk("rst_pmem_write", LW'(pmem_write), '0);
    chk("rst_pmem_addr", LW'(pmem_addr), '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_resps", LW'({i_resp, d_resp}), '0);
    @(negedge clk);
    rst       = 1'b1;
    mon_en    = 1'b1;
    pmem_auto = 1'b1;

    do_round(1'b1, 32'h0000_0060, 1'b0, 1'b0, '0, '0, 1'b0);
    do_round(1'b0, '0, 1'b0, 1'b1, 32'h0000_1020, {8{32'h1234_5678}}, 1'b0);
    do_round(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, '0, 1'b0);
    do_round(1'b0, '0, 1'b1, 1'b0, 32'h0000_0280, '0, 1'b0);
    do_round(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, '0, 1'b0);
    line = rand_line();
    do_round(1'b0, '0, 1'b0, 1'b1, 32'h0000_0300, line, 1'b1);
    do_round(1'b1, 32'h0000_0700, 1'b0, 1'b1, 32'h0000_0300, line, 1'b1);
    do_round(1'b0, '0, 1'b1, 1'b1, 32'h0000_0360, line, 1'b0);

    // Reset during SERVE_I abandons the transaction with no resp.
    @(negedge clk);
    mon_en    = 1'b0;
    pmem_auto = 1'b0;
    i_read    = 1'b1;
    i_addr    = 32'h0000_0500;
    @(negedge clk);
    #1;
    chk("rst_mid_strobe_before", LW'(pmem_read), LW'(1));
    rst = 1'b0;
    #1;
    chk("rst_mid_pmem_read", LW'(pmem_read), '0);
    chk("rst_mid_pmem_addr", LW'(pmem_addr), '0);
    pmem_resp = 1'b1;
    #1;
    chk("rst_mid_no_resp", LW'({i_resp, d_resp}), '0);
    @(negedge clk);
    pmem_resp    = 1'b0;
    i_read       = 1'b0;
    rst          = 1'b1;
    model_last_d = 1'b0;
    @(negedge clk);
    mon_en    = 1'b1;
    pmem_auto = 1'b1;
    do_round(1'b1, 32'h0000_0540, 1'b0, 1'b0, '0, '0, 1'b0);

    for (int r = 0; r < 250; r++) begin
      ir   = ($urandom_range(0, 1) == 1);
      dsel = $urandom_range(0, 3);
      if (!ir && dsel == 0) ir = 1'b1;
      do_round(ir, $urandom, dsel[0], dsel[1], $urandom, rand_line(), ($urandom_range(0, 1) == 1));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", LW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
